// File: rtl/mem_ctrl.sv
// Byte-serialising memory responder: rom (fetch) and ram (data) word ports onto one
// byte-wide 1-cycle-latency SRAM. Optional one-entry fetch buffer: MEMCTRL_FETCH_BUF_EN.
module mem_ctrl #(
  parameter int          MEM_AW   = 17,
  parameter logic [31:0] RST_DATA = 32'h0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              rom_ready_o,
  input  logic              ram_read_op_i,
  input  logic              ram_write_op_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [3:0]        ram_mask_i,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       ram_data_o,
  output logic              ram_ready_o,
  output logic              stallreq_o,
  output logic [MEM_AW-1:0] sram_addr_o,
  output logic              sram_we_o,
  output logic [7:0]        sram_wdata_o,
  input  logic [7:0]        sram_rdata_i,
  output logic [2:0]        state_dbg
);

  localparam int WAW = MEM_AW - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_TAIL = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    P_FETCH = 2'd0,
    P_READ  = 2'd1,
    P_WRITE = 2'd2
  } port_t;

  state_t         state, state_n;
  port_t          port, sel_port, done_port;
  logic [WAW-1:0] base, sel_base, done_base;
  logic [3:0]     pend, pend_clr;
  logic [31:0]    wdata;
  logic [23:0]    asm_word;
  logic [31:0]    rd_word;
  logic [1:0]     cnt, lane;
  logic           start, enter_done;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{rom_addr_i[31:MEM_AW], rom_addr_i[1:0],
                              ram_addr_i[31:MEM_AW], ram_addr_i[1:0]};

`ifdef MEMCTRL_FETCH_BUF_EN
  logic           buf_valid;
  logic [WAW-1:0] buf_tag;
  logic [31:0]    buf_data;
  logic           buf_hit;

  assign buf_hit = buf_valid && (rom_addr_i[MEM_AW-1:2] == buf_tag);
`endif

  // Lowest still-pending write lane; lanes with a clear mask bit never get a cycle.
  always_comb begin
    lane = 2'd0;
    if (pend[0])      lane = 2'd0;
    else if (pend[1]) lane = 2'd1;
    else if (pend[2]) lane = 2'd2;
    else if (pend[3]) lane = 2'd3;
  end

  assign pend_clr = pend & ~(4'b0001 << lane);
  assign rd_word  = {sram_rdata_i, asm_word};

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    sel_port = P_FETCH;
    sel_base = rom_addr_i[MEM_AW-1:2];
    case (state)
      IDLE: begin
        if (ram_write_op_i) begin
          start    = 1'b1;
          sel_port = P_WRITE;
          sel_base = ram_addr_i[MEM_AW-1:2];
          state_n  = (ram_mask_i == 4'b0000) ? DONE : WR;
        end else if (ram_read_op_i) begin
          start    = 1'b1;
          sel_port = P_READ;
          sel_base = ram_addr_i[MEM_AW-1:2];
          state_n  = RD;
        end else if (rom_ce_i) begin
          start    = 1'b1;
          sel_port = P_FETCH;
          sel_base = rom_addr_i[MEM_AW-1:2];
          state_n  = RD;
`ifdef MEMCTRL_FETCH_BUF_EN
          if (buf_hit) state_n = DONE;
`endif
        end
      end
      RD:      if (cnt == 2'd3) state_n = RD_TAIL;
      RD_TAIL: state_n = DONE;
      WR:      if (pend_clr == 4'b0000) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_done = (state_n == DONE) && (state != DONE);
  assign done_port  = start ? sel_port : port;
  assign done_base  = start ? sel_base : base;

  always_comb begin
    sram_addr_o  = '0;
    sram_we_o    = 1'b0;
    sram_wdata_o = 8'h00;
    case (state)
      RD: sram_addr_o = {base, cnt};
      WR: begin
        sram_we_o    = 1'b1;
        sram_addr_o  = {base, lane};
        sram_wdata_o = wdata[{lane, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign stallreq_o = (ram_read_op_i | ram_write_op_i | rom_ce_i) & ~(ram_ready_o | rom_ready_o);
  assign state_dbg  = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      port        <= P_FETCH;
      base        <= '0;
      pend        <= 4'b0000;
      wdata       <= 32'h0;
      asm_word    <= 24'h0;
      cnt         <= 2'd0;
      rom_ready_o <= 1'b0;
      ram_ready_o <= 1'b0;
      rom_data_o  <= RST_DATA;
      ram_data_o  <= RST_DATA;
    end else begin
      state       <= state_n;
      rom_ready_o <= 1'b0;
      ram_ready_o <= 1'b0;
      if (start) begin
        port  <= sel_port;
        base  <= sel_base;
        pend  <= ram_mask_i;
        wdata <= ram_data_i;
        cnt   <= 2'd0;
      end
      // The byte for address k arrives one cycle later, so slot k-1 is filled at step k.
      if (state == RD) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd1:    asm_word[7:0]   <= sram_rdata_i;
          2'd2:    asm_word[15:8]  <= sram_rdata_i;
          2'd3:    asm_word[23:16] <= sram_rdata_i;
          default: ;
        endcase
      end
      if (state == WR) pend <= pend_clr;
      if (enter_done) begin
        case (done_port)
          P_FETCH: begin
            rom_ready_o <= 1'b1;
`ifdef MEMCTRL_FETCH_BUF_EN
            rom_data_o  <= (state == IDLE) ? buf_data : rd_word;
`else
            rom_data_o  <= rd_word;
`endif
          end
          P_READ: begin
            ram_ready_o <= 1'b1;
            ram_data_o  <= rd_word;
          end
          default: ram_ready_o <= 1'b1;
        endcase
      end
    end
  end

`ifdef MEMCTRL_FETCH_BUF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= 32'h0;
    end else if (enter_done) begin
      if (done_port == P_FETCH) begin
        buf_valid <= 1'b1;
        buf_tag   <= done_base;
        buf_data  <= (state == IDLE) ? buf_data : rd_word;
      end else if ((done_port == P_WRITE) && (done_base == buf_tag)) begin
        buf_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide SRAM model, latency/stall/data checks per scenario.
module tb_mem_ctrl;

  localparam int MEM_AW = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              rom_ce;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_data;
  logic              rom_ready;
  logic              ram_read;
  logic              ram_write;
  logic [31:0]       ram_addr;
  logic [3:0]        ram_mask;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_data;
  logic              ram_ready;
  logic              stallreq;
  logic [MEM_AW-1:0] sram_addr;
  logic              sram_we;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]        mem [0:(1<<MEM_AW)-1];
  int                we_cnt  = 0;
  int                rd_cyc  = 0;
  int                rdy_cnt = 0;
  logic [MEM_AW-1:0] we_addr = '0;
  logic [7:0]        we_byte = 8'h00;

  always #5 clk = ~clk;

  mem_ctrl #(.MEM_AW(MEM_AW), .RST_DATA(32'h0)) dut (
    .CLK(clk), .RST(rst),
    .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data), .rom_ready_o(rom_ready),
    .ram_read_op_i(ram_read), .ram_write_op_i(ram_write), .ram_addr_i(ram_addr),
    .ram_mask_i(ram_mask), .ram_data_i(ram_wdata), .ram_data_o(ram_data), .ram_ready_o(ram_ready),
    .stallreq_o(stallreq), .sram_addr_o(sram_addr), .sram_we_o(sram_we),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata), .state_dbg(state_dbg)
  );

  // SRAM: write on strobe, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  always @(posedge clk) begin
    if (sram_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = sram_addr;
      we_byte = sram_wdata;
    end
    if (state_dbg == 3'd1) rd_cyc = rd_cyc + 1;
    if (rom_ready || ram_ready) rdy_cnt = rdy_cnt + 1;
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic drop_inputs();
    rom_ce = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
    rom_addr = 32'h0; ram_addr = 32'h0; ram_mask = 4'h0; ram_wdata = 32'h0;
  endtask

  // Starts in an IDLE cycle (#1 after an edge); returns #1 into the next IDLE cycle.
  task automatic access(input int kind, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input string name,
                        output int lat, output logic [31:0] rd);
    logic got;
    int   stall_bad;
    case (kind)
      0: begin rom_ce = 1'b1; rom_addr = addr; end
      1: begin ram_read = 1'b1; ram_addr = addr; end
      default: begin ram_write = 1'b1; ram_addr = addr; ram_mask = mask; ram_wdata = data; end
    endcase
    #1;
    stall_bad = (stallreq !== 1'b1) ? 1 : 0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if ((kind == 0) ? rom_ready : ram_ready) got = 1'b1;
      else if (stallreq !== 1'b1) stall_bad++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL %s timeout: no ready within %0d cycles", name, lat); end
    checks++;
    if (stall_bad !== 0) begin errors++; $display("FAIL %s stall_busy: low in %0d busy cycles, required 0", name, stall_bad); end
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("FAIL %s stall_ready: got %b required 0", name, stallreq); end
    rd = (kind == 0) ? rom_data : ram_data;
    drop_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (rom_data !== 32'h0)  begin errors++; $display("FAIL reset_rom_data got %h required 00000000", rom_data); end
    checks++; if (ram_data !== 32'h0)  begin errors++; $display("FAIL reset_ram_data got %h required 00000000", ram_data); end
    checks++; if (rom_ready !== 1'b0)  begin errors++; $display("FAIL reset_rom_ready got %b required 0", rom_ready); end
    checks++; if (ram_ready !== 1'b0)  begin errors++; $display("FAIL reset_ram_ready got %b required 0", ram_ready); end
    checks++; if (stallreq !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b required 0", stallreq); end
    checks++; if (sram_we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b required 0", sram_we); end
    checks++; if (sram_addr !== '0)    begin errors++; $display("FAIL reset_sram_addr got %h required 0", sram_addr); end
    checks++; if (sram_wdata !== 8'h0) begin errors++; $display("FAIL reset_sram_wdata got %h required 00", sram_wdata); end
    checks++; if (state_dbg !== 3'd0)  begin errors++; $display("FAIL reset_state got %0d required 0", state_dbg); end
  endtask

  task automatic test_fetch();
    int lat; logic [31:0] rd;
    rd_cyc = 0;
    access(0, 32'h0, 4'h0, 32'h0, "fetch0", lat, rd);
    checks++; if (lat !== 6)            begin errors++; $display("FAIL fetch_latency got %0d required 6", lat); end
    checks++; if (rd !== 32'h00100513)  begin errors++; $display("FAIL fetch_data got %h required 00100513", rd); end
    checks++; if (rd_cyc !== 4)         begin errors++; $display("FAIL fetch_rd_cycles got %0d required 4", rd_cyc); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd;
    we_cnt = 0;
    access(2, 32'h40, 4'hF, 32'hDEADBEEF, "write_full", lat, rd);
    checks++; if (lat !== 5)                     begin errors++; $display("FAIL wr_full_latency got %0d required 5", lat); end
    checks++; if (we_cnt !== 4)                  begin errors++; $display("FAIL wr_full_strobes got %0d required 4", we_cnt); end
    checks++; if (mem_word(32'h40) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_full_sram got %h required deadbeef", mem_word(32'h40)); end
    access(1, 32'h40, 4'h0, 32'h0, "read_full", lat, rd);
    checks++; if (lat !== 6)                     begin errors++; $display("FAIL rd_latency got %0d required 6", lat); end
    checks++; if (rd !== 32'hDEADBEEF)           begin errors++; $display("FAIL rd_data got %h required deadbeef", rd); end
  endtask

  task automatic test_partial_write();
    int lat; logic [31:0] rd;
    we_cnt = 0;
    access(2, 32'h40, 4'b0100, 32'h00AA0000, "write_lane2", lat, rd);
    checks++; if (lat !== 2)         begin errors++; $display("FAIL wr_lane2_latency got %0d required 2", lat); end
    checks++; if (we_cnt !== 1)      begin errors++; $display("FAIL wr_lane2_strobes got %0d required 1", we_cnt); end
    checks++; if (we_addr !== 17'h42) begin errors++; $display("FAIL wr_lane2_addr got %h required 42", we_addr); end
    checks++; if (we_byte !== 8'hAA) begin errors++; $display("FAIL wr_lane2_byte got %h required aa", we_byte); end
    access(1, 32'h40, 4'h0, 32'h0, "read_lane2", lat, rd);
    checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL rd_lane2_data got %h required deaabeef", rd); end
    we_cnt = 0;
    access(2, 32'h40, 4'b0000, 32'hFFFFFFFF, "write_empty", lat, rd);
    checks++; if (lat !== 1)           begin errors++; $display("FAIL wr_empty_latency got %0d required 1", lat); end
    checks++; if (we_cnt !== 0)        begin errors++; $display("FAIL wr_empty_strobes got %0d required 0", we_cnt); end
    checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL wr_keeps_ram_data got %h required deaabeef", rd); end
    we_cnt = 0;
    access(2, 32'h40, 4'b1010, 32'h11223344, "write_sparse", lat, rd);
    checks++; if (lat !== 3)            begin errors++; $display("FAIL wr_sparse_latency got %0d required 3", lat); end
    checks++; if (we_cnt !== 2)         begin errors++; $display("FAIL wr_sparse_strobes got %0d required 2", we_cnt); end
    checks++; if (we_addr !== 17'h43)   begin errors++; $display("FAIL wr_sparse_last_addr got %h required 43", we_addr); end
    checks++; if (we_byte !== 8'h11)    begin errors++; $display("FAIL wr_sparse_last_byte got %h required 11", we_byte); end
    // High address bits are dropped and the low two bits ignored.
    access(1, 32'hFFFE0043, 4'h0, 32'h0, "read_trunc", lat, rd);
    checks++; if (rd !== 32'h11AA33EF)  begin errors++; $display("FAIL rd_trunc_data got %h required 11aa33ef", rd); end
  endtask

  task automatic test_priority();
    int lat; int stall_bad; logic early;
    rom_ce = 1'b1; rom_addr = 32'h0; ram_read = 1'b1; ram_addr = 32'h40;
    #1;
    stall_bad = (stallreq !== 1'b1) ? 1 : 0;
    early = 1'b0;
    lat = 0;
    while (!ram_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rom_ready) early = 1'b1;
      if (!ram_ready && stallreq !== 1'b1) stall_bad++;
    end
    checks++; if (lat !== 6)            begin errors++; $display("FAIL prio_read_latency got %0d required 6", lat); end
    checks++; if (early !== 1'b0)       begin errors++; $display("FAIL prio_fetch_first got %b required 0", early); end
    checks++; if (ram_data !== 32'h11AA33EF) begin errors++; $display("FAIL prio_read_data got %h required 11aa33ef", ram_data); end
    checks++; if (stallreq !== 1'b0)    begin errors++; $display("FAIL prio_stall_ram_ready got %b required 0", stallreq); end
    ram_read = 1'b0; ram_addr = 32'h0;
    lat = 0;
    while (!rom_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!rom_ready && stallreq !== 1'b1) stall_bad++;
    end
    checks++; if (lat !== 7)            begin errors++; $display("FAIL prio_fetch_latency got %0d required 7", lat); end
    checks++; if (rom_data !== 32'h00100513) begin errors++; $display("FAIL prio_fetch_data got %h required 00100513", rom_data); end
    checks++; if (stallreq !== 1'b0)    begin errors++; $display("FAIL prio_stall_rom_ready got %b required 0", stallreq); end
    checks++; if (stall_bad !== 0)      begin errors++; $display("FAIL prio_stall_busy low in %0d cycles, required 0", stall_bad); end
    drop_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    rdy_cnt = 0;
    ram_write = 1'b1; ram_addr = 32'h80; ram_mask = 4'hF; ram_wdata = 32'h44332211;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (sram_we !== 1'b1 || sram_addr !== 17'h81) begin errors++; $display("FAIL mid_second_wr got we=%b addr=%h required we=1 addr=81", sram_we, sram_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drop_inputs();
    #1;
    checks++; if (state_dbg !== 3'd0)   begin errors++; $display("FAIL mid_state got %0d required 0", state_dbg); end
    checks++; if (ram_data !== 32'h0)   begin errors++; $display("FAIL mid_ram_data got %h required 00000000", ram_data); end
    checks++; if (rom_data !== 32'h0)   begin errors++; $display("FAIL mid_rom_data got %h required 00000000", rom_data); end
    checks++; if (stallreq !== 1'b0)    begin errors++; $display("FAIL mid_stall got %b required 0", stallreq); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (rdy_cnt !== 0)        begin errors++; $display("FAIL mid_no_ready got %0d pulses required 0", rdy_cnt); end
    checks++; if (mem_word(32'h80) !== 32'h00002211) begin errors++; $display("FAIL mid_sram got %h required 00002211", mem_word(32'h80)); end
  endtask

  task automatic test_fetch_buf();
    int lat; logic [31:0] rd; int exp_lat; int exp_rd;
`ifdef MEMCTRL_FETCH_BUF_EN
    exp_lat = 1; exp_rd = 0;
`else
    exp_lat = 6; exp_rd = 4;
`endif
    access(0, 32'h0, 4'h0, 32'h0, "buf_fill", lat, rd);
    checks++; if (lat !== 6) begin errors++; $display("FAIL buf_fill_latency got %0d required 6", lat); end
    rd_cyc = 0;
    access(0, 32'h0, 4'h0, 32'h0, "buf_again", lat, rd);
    checks++; if (lat !== exp_lat)      begin errors++; $display("FAIL buf_again_latency got %0d required %0d", lat, exp_lat); end
    checks++; if (rd_cyc !== exp_rd)    begin errors++; $display("FAIL buf_again_rd_cycles got %0d required %0d", rd_cyc, exp_rd); end
    checks++; if (rd !== 32'h00100513)  begin errors++; $display("FAIL buf_again_data got %h required 00100513", rd); end
    access(2, 32'h0, 4'hF, 32'hCAFEF00D, "buf_write", lat, rd);
    rd_cyc = 0;
    access(0, 32'h0, 4'h0, 32'h0, "buf_after_wr", lat, rd);
    checks++; if (lat !== 6)            begin errors++; $display("FAIL buf_after_wr_latency got %0d required 6", lat); end
    checks++; if (rd_cyc !== 4)         begin errors++; $display("FAIL buf_after_wr_rd_cycles got %0d required 4", rd_cyc); end
    checks++; if (rd !== 32'hCAFEF00D)  begin errors++; $display("FAIL buf_after_wr_data got %h required cafef00d", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drop_inputs();
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 8'h00;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_fetch();
    test_write_read();
    test_partial_write();
    test_priority();
    test_reset_mid();
    test_fetch_buf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side responder for the core's instruction (rom) and data (ram) ports.
- Serialises both word-wide ports onto one byte-wide synchronous SRAM with 1-cycle read latency.
- Data accesses take priority over instruction fetches.
- Drives a stall request to the pipeline controller while any accepted or pending access is incomplete.

Parameters:
- MEM_AW, 17, byte-address width of the backing SRAM; core address bits above MEM_AW are ignored.
- RST_DATA, 32'h0, reset value of rom_data_o and ram_data_o.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- rom_ce_i  in  1  instruction fetch request
- rom_addr_i  in  32  fetch byte address; bits [1:0] ignored
- rom_data_o  out  32  fetched word, little-endian
- rom_ready_o  out  1  one-cycle pulse: fetch complete, rom_data_o valid
- ram_read_op_i  in  1  data read request
- ram_write_op_i  in  1  data write request
- ram_addr_i  in  32  data byte address; bits [1:0] ignored
- ram_mask_i  in  4  byte-lane enables; bit i = byte i
- ram_data_i  in  32  write data; byte i = bits [8i+7:8i]
- ram_data_o  out  32  read word
- ram_ready_o  out  1  one-cycle pulse: data access complete
- stallreq_o  out  1  to pipeline controller; hold pipeline
- sram_addr_o  out  MEM_AW  SRAM byte address
- sram_we_o  out  1  SRAM write strobe
- sram_wdata_o  out  8  SRAM write byte
- sram_rdata_i  in  8  SRAM read byte; valid the cycle after its address

Behaviour:
- Reset values: all outputs 0, except rom_data_o and ram_data_o = RST_DATA. State = IDLE.
- Requests are level signals. The core holds request inputs stable until the matching ready pulse.
- Word base address is {addr[MEM_AW-1:2], 2'b00}; byte i lives at base+i.
- IDLE, request select, in priority order:
  - ram_write_op_i -> WR. Write wins if both read and write ops are high; that case is a protocol violation.
  - ram_read_op_i -> RD (data read).
  - rom_ce_i -> RD (fetch).
  - None -> stay in IDLE.
- On leaving IDLE, the selected address, mask, wdata and port are latched. Inputs are not sampled again until IDLE.
- RD:
  - 4 cycles; 2-bit counter k = 0..3.
  - sram_addr_o = base+k, sram_we_o = 0.
  - sram_rdata_i is captured into byte k-1 of the assembly register.
  - After k=3 -> RD_TAIL.
- RD_TAIL: capture byte 3 -> DONE.
- WR:
  - One cycle per set bit of the latched mask, ascending lane order. Unmasked lanes are skipped with no cycle spent.
  - sram_we_o = 1, sram_addr_o = base+lane, sram_wdata_o = latched byte of that lane.
  - After the last enabled lane -> DONE. Mask 4'b0000 goes IDLE -> DONE directly.
- DONE, 1 cycle:
  - Data read: ram_ready_o = 1 and ram_data_o loaded.
  - Write: ram_ready_o = 1; ram_data_o unchanged.
  - Fetch: rom_ready_o = 1 and rom_data_o loaded.
  - Next state IDLE.
- Ready and data outputs are registered. Data outputs hold until the next completion on the same port.
- Latency from the IDLE cycle that accepts a request to its ready pulse:
  - Read: 6 cycles.
  - Write: N+1 cycles, N = popcount(mask); empty mask = 1.
- stallreq_o = (ram_read_op_i | ram_write_op_i | rom_ce_i) & ~(ram_ready_o | rom_ready_o), combinational.
- Starvation: a data op held high every IDLE cycle starves fetches. This is acceptable because the core cannot issue back-to-back data ops without fetching.
- sram_we_o is 0 in every state except WR.
- Reset mid-operation:
  - Return to IDLE and drop the access.
  - SRAM bytes already written stay written.
  - No ready pulse is produced.
  - Data outputs return to RST_DATA.
- Address bits above MEM_AW are truncated silently; there is no fault.

Optional Feature:
- Macro: MEMCTRL_FETCH_BUF_EN.
- Defined:
  - Adds a one-entry fetch buffer: word address tag, data and valid bit; valid cleared on reset.
  - Every fetch completion loads the buffer.
  - In IDLE, a fetch whose word address equals the tag with valid = 1 (and no data op pending) goes IDLE -> DONE. rom_ready_o rises 1 cycle later with the buffered word, and no SRAM cycles are issued.
  - Any write whose word address equals the tag clears valid when the write enters DONE.
- Undefined: every fetch takes the full 6-cycle RD path, and none of the buffer logic exists.

Test Plan:
- Preload SRAM[0..3] = 8'h13,8'h05,8'h10,8'h00; rom_ce_i=1, rom_addr_i=0 -> rom_ready_o pulses 6 cycles after acceptance, rom_data_o=32'h00100513, stallreq_o low only in the ready cycle.
- Write addr 32'h40, mask 4'b1111, data 32'hDEADBEEF, then read addr 32'h40 -> write ready after 5 cycles, SRAM[0x40..0x43]=EF,BE,AD,DE, read returns 32'hDEADBEEF.
- Write addr 32'h40, mask 4'b0100, data 32'h00AA0000 -> exactly one sram_we_o cycle at address 0x42 with byte AA, ready after 2 cycles; readback 32'hDEAABEEF. Mask 4'b0000 -> no sram_we_o, ready 1 cycle after acceptance.
- rom_ce_i and ram_read_op_i both asserted in IDLE -> data read is served first (ram_ready_o), fetch follows, rom_ready_o pulses 6 cycles after its acceptance; stallreq_o is high throughout except the two ready cycles.
- Assert RST for one cycle during the 2nd WR cycle of a mask 4'b1111 write -> state returns to IDLE, no ready pulse, only bytes 0 and 1 are modified, outputs return to reset values.
- With MEMCTRL_FETCH_BUF_EN, fetch 0x0 twice -> second rom_ready_o arrives 1 cycle after acceptance with no SRAM reads. Then write to 0x0 and fetch again -> the fetch takes 6 cycles and returns the new data.
